// File: rtl/ebike_pkg.sv
// ebike_pkg: shared definitions for the e-bike motor drive path.
//   sel_t       per-phase mode code from the commutation block
//   PWM_W       PWM counter / duty width
//   PWM_MAX     last count value of a PWM period
//   sel_decode  maps a mode code and the PWM level to a requested {hi, lo} gate pair
package ebike_pkg;

  localparam int PWM_W = 11;
  localparam logic [PWM_W-1:0] PWM_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    HIGH_Z     = 2'b00,
    REV_CURR   = 2'b01,
    FRWRD_CURR = 2'b10,
    BRAKE      = 2'b11
  } sel_t;

  // Returns {hi, lo}. Brake only ever pulses the low side.
  function automatic logic [1:0] sel_decode(input sel_t sel, input logic pwm);
    logic [1:0] req;
    case (sel)
      HIGH_Z:     req = 2'b00;
      REV_CURR:   req = {~pwm, pwm};
      FRWRD_CURR: req = {pwm, ~pwm};
      BRAKE:      req = {1'b0, pwm};
      default:    req = 2'b00;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/nonoverlap.sv
// nonoverlap: dead-time interlock for one half-bridge leg.
//   clk, rst_n      clock, asynchronous active-low reset
//   hi_in, lo_in    requested gate pair
//   hi_out, lo_out  registered gate drives
//   DEAD            clocks both gates stay off after any request change (2..255)
// The request is registered first and then compared with its previous value,
// so a request change seen at edge t blanks the outputs from edge t+1 and the
// new pair appears at edge t+DEAD+1, giving exactly DEAD blanked clocks.
module nonoverlap #(
  parameter int DEAD = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hi_in,
  input  logic lo_in,
  output logic hi_out,
  output logic lo_out
);

  localparam logic [7:0] DEAD_LAST = 8'(DEAD - 1);

  logic [1:0] req_r;
  logic [1:0] prev_r;
  logic [7:0] dead_cnt_r;

  // Request pipeline, dead counter and gate output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r      <= 2'b00;
      prev_r     <= 2'b00;
      dead_cnt_r <= 8'd0;
      hi_out     <= 1'b0;
      lo_out     <= 1'b0;
    end else begin
      req_r  <= {hi_in, lo_in};
      prev_r <= req_r;
      if (req_r != prev_r) begin
        dead_cnt_r <= 8'd0;
        hi_out     <= 1'b0;
        lo_out     <= 1'b0;
      end else if (dead_cnt_r >= DEAD_LAST) begin
        // Counter saturates here; a (1,1) request is never passed through.
        if (req_r == 2'b11) begin
          hi_out <= 1'b0;
          lo_out <= 1'b0;
        end else begin
          hi_out <= req_r[1];
          lo_out <= req_r[0];
        end
      end else begin
        dead_cnt_r <= dead_cnt_r + 8'd1;
        hi_out     <= 1'b0;
        lo_out     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: three-phase gate-drive stage.
//   clk, rst_n                       clock, asynchronous active-low reset
//   duty[10:0]                       PWM on-time out of a 2048-clock period
//   sel_grn, sel_yellow, sel_blue    per-phase mode codes (ebike_pkg::sel_t)
//   grn_hi/lo, ylw_hi/lo, blu_hi/lo  registered gate drives
//   pwm_synch                        one-cycle pulse while the counter is at 2047
//   DEAD                             non-overlap dead time in clocks
// Optional feature macro MTR_DRV_DUTY_LATCH_EN: duty is latched at the period
// boundary; otherwise duty is used combinationally and acts mid-period.
module mtr_drv
  import ebike_pkg::*;
#(
  parameter int DEAD = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  input  logic [1:0]       sel_grn,
  input  logic [1:0]       sel_yellow,
  input  logic [1:0]       sel_blue,
  output logic             grn_hi,
  output logic             grn_lo,
  output logic             ylw_hi,
  output logic             ylw_lo,
  output logic             blu_hi,
  output logic             blu_lo,
  output logic             pwm_synch
);

  logic [PWM_W-1:0] cnt_r;
  logic             pwm_r;
  logic             synch_r;
  logic [PWM_W-1:0] duty_eff_s;
  logic [1:0]       req_grn_s;
  logic [1:0]       req_ylw_s;
  logic [1:0]       req_blu_s;

  // Free-running period counter, PWM comparator and sync pulse.
  // synch_r is set one count early so it is high while cnt_r holds PWM_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 11'd0;
      pwm_r   <= 1'b0;
      synch_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_r + 11'd1;
      pwm_r   <= (cnt_r < duty_eff_s);
      synch_r <= (cnt_r == (PWM_MAX - 11'd1));
    end
  end

`ifdef MTR_DRV_DUTY_LATCH_EN
  logic [PWM_W-1:0] duty_eff_r;

  // Duty latch, loaded only in the last cycle of a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_eff_r <= 11'd0;
    end else if (cnt_r == PWM_MAX) begin
      duty_eff_r <= duty;
    end else begin
      duty_eff_r <= duty_eff_r;
    end
  end

  assign duty_eff_s = duty_eff_r;
`else
  assign duty_eff_s = duty;
`endif

  // Per-phase select decoders.
  always_comb begin
    req_grn_s = sel_decode(sel_t'(sel_grn), pwm_r);
    req_ylw_s = sel_decode(sel_t'(sel_yellow), pwm_r);
    req_blu_s = sel_decode(sel_t'(sel_blue), pwm_r);
  end

  nonoverlap #(.DEAD(DEAD)) u_no_grn (
    .clk(clk), .rst_n(rst_n),
    .hi_in(req_grn_s[1]), .lo_in(req_grn_s[0]),
    .hi_out(grn_hi), .lo_out(grn_lo)
  );

  nonoverlap #(.DEAD(DEAD)) u_no_ylw (
    .clk(clk), .rst_n(rst_n),
    .hi_in(req_ylw_s[1]), .lo_in(req_ylw_s[0]),
    .hi_out(ylw_hi), .lo_out(ylw_lo)
  );

  nonoverlap #(.DEAD(DEAD)) u_no_blu (
    .clk(clk), .rst_n(rst_n),
    .hi_in(req_blu_s[1]), .lo_in(req_blu_s[0]),
    .hi_out(blu_hi), .lo_out(blu_lo)
  );

  assign pwm_synch = synch_r;

endmodule
